wb_arbiter: RTL and testbench

Round-robin arbiter that shares the single ROB writeback port among the three result-producing pipelines: ALU, MEM (fed by the M/WB pipeline register) and MUL. Each cycle it grants at most one valid requester, stalls the other valid requesters so their writeback registers hold, and registers the winner's payload onto the ROB write port. It sits between the per-pipeline writeback registers and the ROB.

---
 rtl/wb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: ALU, MEM and MUL share one ROB write port.
// Grant and stall are combinational; the winner's payload is registered onto the ROB port.
module wb_arbiter #(
  parameter int unsigned WORD_SIZE       = 32,
  parameter int unsigned ROB_ENTRY_WIDTH = 3,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic [ROB_ENTRY_WIDTH-1:0] alu_rob_id,
  input  logic [WORD_SIZE-1:0]       alu_data,
  input  logic [WORD_SIZE-1:0]       alu_pc,
  input  logic                       alu_exception,
  input  logic [WORD_SIZE-1:0]       alu_virtual_addr_exception,
  input  logic                       mem_valid,
  input  logic [ROB_ENTRY_WIDTH-1:0] mem_rob_id,
  input  logic [WORD_SIZE-1:0]       mem_data,
  input  logic [WORD_SIZE-1:0]       mem_pc,
  input  logic                       mem_exception,
  input  logic [WORD_SIZE-1:0]       mem_virtual_addr_exception,
  input  logic                       mul_valid,
  input  logic [ROB_ENTRY_WIDTH-1:0] mul_rob_id,
  input  logic [WORD_SIZE-1:0]       mul_data,
  input  logic [WORD_SIZE-1:0]       mul_pc,
  input  logic                       mul_exception,
  input  logic [WORD_SIZE-1:0]       mul_virtual_addr_exception,
  output logic                       alu_stall,
  output logic                       mem_stall,
  output logic                       mul_stall,
  output logic                       rob_wvalid,
  output logic [ROB_ENTRY_WIDTH-1:0] rob_wid,
  output logic [WORD_SIZE-1:0]       rob_wdata,
  output logic [WORD_SIZE-1:0]       rob_wpc,
  output logic                       rob_wexception,
  output logic [WORD_SIZE-1:0]       rob_wvaddr,
  output logic [1:0]                 rob_wsrc,
  output logic [CNT_WIDTH-1:0]       conflict_count
);

  typedef enum logic [1:0] {SRC_ALU = 2'd0, SRC_MEM = 2'd1, SRC_MUL = 2'd2, SRC_BAD = 2'd3} src_e;

  src_e                       last_grant_q, last_grant_d;
  src_e                       lg, o0, o1, o2, grant_idx;
  logic                       grant_vld;
  logic [2:0]                 valid_vec;
  logic                       conflict;

  logic                       wvalid_q, wvalid_d;
  logic [ROB_ENTRY_WIDTH-1:0] wid_q, wid_d;
  logic [WORD_SIZE-1:0]       wdata_q, wdata_d;
  logic [WORD_SIZE-1:0]       wpc_q, wpc_d;
  logic                       wexc_q, wexc_d;
  logic [WORD_SIZE-1:0]       wvaddr_q, wvaddr_d;
  logic [1:0]                 wsrc_q, wsrc_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;

  assign valid_vec = {mul_valid, mem_valid, alu_valid};
  assign conflict  = (alu_valid & mem_valid) | (alu_valid & mul_valid) | (mem_valid & mul_valid);

  // Rotating priority: the requester after the last winner goes first; 3 aliases to MUL.
  always_comb begin
    lg        = (last_grant_q == SRC_BAD) ? SRC_MUL : last_grant_q;
    o0        = SRC_ALU;
    o1        = SRC_MEM;
    o2        = SRC_MUL;
    grant_vld = 1'b0;
    grant_idx = SRC_ALU;
    case (lg)
      SRC_ALU: begin o0 = SRC_MEM; o1 = SRC_MUL; o2 = SRC_ALU; end
      SRC_MEM: begin o0 = SRC_MUL; o1 = SRC_ALU; o2 = SRC_MEM; end
      default: begin o0 = SRC_ALU; o1 = SRC_MEM; o2 = SRC_MUL; end
    endcase
    if (!reset) begin
      if (valid_vec[o0]) begin
        grant_vld = 1'b1;
        grant_idx = o0;
      end else if (valid_vec[o1]) begin
        grant_vld = 1'b1;
        grant_idx = o1;
      end else if (valid_vec[o2]) begin
        grant_vld = 1'b1;
        grant_idx = o2;
      end
    end
  end

  assign alu_stall = alu_valid && !(grant_vld && grant_idx == SRC_ALU);
  assign mem_stall = mem_valid && !(grant_vld && grant_idx == SRC_MEM);
  assign mul_stall = mul_valid && !(grant_vld && grant_idx == SRC_MUL);

  // Next-state: capture winner payload, hold payload when idle, saturate conflict counter.
  always_comb begin
    last_grant_d = last_grant_q;
    wvalid_d     = 1'b0;
    wid_d        = wid_q;
    wdata_d      = wdata_q;
    wpc_d        = wpc_q;
    wexc_d       = wexc_q;
    wvaddr_d     = wvaddr_q;
    wsrc_d       = wsrc_q;
    cnt_d        = cnt_q;
    if (grant_vld) begin
      wvalid_d     = 1'b1;
      last_grant_d = grant_idx;
      wsrc_d       = 2'(grant_idx);
      case (grant_idx)
        SRC_MEM: begin
          wid_d = mem_rob_id; wdata_d = mem_data; wpc_d = mem_pc;
          wexc_d = mem_exception; wvaddr_d = mem_virtual_addr_exception;
        end
        SRC_MUL: begin
          wid_d = mul_rob_id; wdata_d = mul_data; wpc_d = mul_pc;
          wexc_d = mul_exception; wvaddr_d = mul_virtual_addr_exception;
        end
        default: begin
          wid_d = alu_rob_id; wdata_d = alu_data; wpc_d = alu_pc;
          wexc_d = alu_exception; wvaddr_d = alu_virtual_addr_exception;
        end
      endcase
    end
    if (conflict && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= SRC_MUL;
      wvalid_q     <= 1'b0;
      wid_q        <= '0;
      wdata_q      <= '0;
      wpc_q        <= '0;
      wexc_q       <= 1'b0;
      wvaddr_q     <= '0;
      wsrc_q       <= 2'd0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wvalid_q     <= wvalid_d;
      wid_q        <= wid_d;
      wdata_q      <= wdata_d;
      wpc_q        <= wpc_d;
      wexc_q       <= wexc_d;
      wvaddr_q     <= wvaddr_d;
      wsrc_q       <= wsrc_d;
      cnt_q        <= cnt_d;
    end
  end

  assign rob_wvalid     = wvalid_q;
  assign rob_wid        = wid_q;
  assign rob_wdata      = wdata_q;
  assign rob_wpc        = wpc_q;
  assign rob_wexception = wexc_q;
  assign rob_wvaddr     = wvaddr_q;
  assign rob_wsrc       = wsrc_q;
  assign conflict_count = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: single-requester path, rotation, exception payload,
// reset in mid-contention and counter saturation, all against hand-computed values.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        v   [3];
  logic [2:0]  id  [3];
  logic [31:0] dat [3];
  logic [31:0] pc  [3];
  logic        exc [3];
  logic [31:0] va  [3];

  logic        alu_stall, mem_stall, mul_stall;
  logic        rob_wvalid, rob_wexception;
  logic [2:0]  rob_wid;
  logic [31:0] rob_wdata, rob_wpc, rob_wvaddr;
  logic [1:0]  rob_wsrc;
  logic [15:0] conflict_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(v[0]), .alu_rob_id(id[0]), .alu_data(dat[0]), .alu_pc(pc[0]),
    .alu_exception(exc[0]), .alu_virtual_addr_exception(va[0]),
    .mem_valid(v[1]), .mem_rob_id(id[1]), .mem_data(dat[1]), .mem_pc(pc[1]),
    .mem_exception(exc[1]), .mem_virtual_addr_exception(va[1]),
    .mul_valid(v[2]), .mul_rob_id(id[2]), .mul_data(dat[2]), .mul_pc(pc[2]),
    .mul_exception(exc[2]), .mul_virtual_addr_exception(va[2]),
    .alu_stall(alu_stall), .mem_stall(mem_stall), .mul_stall(mul_stall),
    .rob_wvalid(rob_wvalid), .rob_wid(rob_wid), .rob_wdata(rob_wdata), .rob_wpc(rob_wpc),
    .rob_wexception(rob_wexception), .rob_wvaddr(rob_wvaddr), .rob_wsrc(rob_wsrc),
    .conflict_count(conflict_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stalls(input string tag, input logic a, input logic m, input logic u);
    #1;
    chk({tag, "_alu_stall"}, 32'(alu_stall), 32'(a));
    chk({tag, "_mem_stall"}, 32'(mem_stall), 32'(m));
    chk({tag, "_mul_stall"}, 32'(mul_stall), 32'(u));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b0; id[i] = 3'(i + 1); dat[i] = 32'h100 + 32'(i);
      pc[i] = 32'h4000 + 32'(i * 4); exc[i] = 1'b0; va[i] = '0;
    end
    tick();
    do_reset();

    // Reset state
    chk("rst_wvalid", 32'(rob_wvalid), 32'd0);
    chk("rst_wid", 32'(rob_wid), 32'd0);
    chk("rst_wdata", rob_wdata, 32'd0);
    chk("rst_wpc", rob_wpc, 32'd0);
    chk("rst_wexc", 32'(rob_wexception), 32'd0);
    chk("rst_wvaddr", rob_wvaddr, 32'd0);
    chk("rst_wsrc", 32'(rob_wsrc), 32'd0);
    chk("rst_cnt", 32'(conflict_count), 32'd0);

    // Single MEM request
    v[1] = 1'b1; id[1] = 3'd5; dat[1] = 32'hDEADBEEF;
    stalls("t1", 1'b0, 1'b0, 1'b0);
    tick();
    v[1] = 1'b0;
    chk("t1_wvalid", 32'(rob_wvalid), 32'd1);
    chk("t1_wid", 32'(rob_wid), 32'd5);
    chk("t1_wdata", rob_wdata, 32'hDEADBEEF);
    chk("t1_wsrc", 32'(rob_wsrc), 32'd1);
    tick();
    chk("t1_wvalid_drop", 32'(rob_wvalid), 32'd0);
    chk("t1_wdata_hold", rob_wdata, 32'hDEADBEEF);

    // All three valid, each drops once granted
    do_reset();
    id[0] = 3'd1; id[1] = 3'd2; id[2] = 3'd3;
    dat[0] = 32'hA0; dat[1] = 32'hB1; dat[2] = 32'hC2;
    v[0] = 1'b1; v[1] = 1'b1; v[2] = 1'b1;
    stalls("t2c0", 1'b0, 1'b1, 1'b1);
    tick();
    chk("t2_src0", 32'(rob_wsrc), 32'd0);
    chk("t2_wid0", 32'(rob_wid), 32'd1);
    chk("t2_pc0", rob_wpc, 32'h4000);
    v[0] = 1'b0;
    stalls("t2c1", 1'b0, 1'b0, 1'b1);
    tick();
    chk("t2_src1", 32'(rob_wsrc), 32'd1);
    chk("t2_data1", rob_wdata, 32'hB1);
    v[1] = 1'b0;
    stalls("t2c2", 1'b0, 1'b0, 1'b0);
    tick();
    v[2] = 1'b0;
    chk("t2_src2", 32'(rob_wsrc), 32'd2);
    chk("t2_wvalid2", 32'(rob_wvalid), 32'd1);
    chk("t2_cnt", 32'(conflict_count), 32'd2);

    // ALU and MUL continuous, MEM idle: ALU, MUL, ALU, MUL
    do_reset();
    v[0] = 1'b1; v[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t3_mem_stall%0d", k), 32'(mem_stall), 32'd0);
      tick();
      chk($sformatf("t3_src%0d", k), 32'(rob_wsrc), (k % 2 == 0) ? 32'd0 : 32'd2);
    end
    chk("t3_cnt", 32'(conflict_count), 32'd4);
    v[0] = 1'b0; v[2] = 1'b0;

    // Exception on MEM contends with ALU; no priority for exceptions
    do_reset();
    v[0] = 1'b1; v[1] = 1'b1; exc[1] = 1'b1; va[1] = 32'h1000;
    stalls("t4c0", 1'b0, 1'b1, 1'b0);
    tick();
    chk("t4_src0", 32'(rob_wsrc), 32'd0);
    chk("t4_exc0", 32'(rob_wexception), 32'd0);
    v[0] = 1'b0;
    tick();
    v[1] = 1'b0;
    chk("t4_src1", 32'(rob_wsrc), 32'd1);
    chk("t4_exc1", 32'(rob_wexception), 32'd1);
    chk("t4_vaddr1", rob_wvaddr, 32'h1000);
    exc[1] = 1'b0; va[1] = '0;

    // All valid; last winner was MEM so MUL goes next, then reset for one cycle
    v[0] = 1'b1; v[1] = 1'b1; v[2] = 1'b1;
    tick();
    chk("t5_src_pre", 32'(rob_wsrc), 32'd2);
    chk("t5_cnt_pre", 32'(conflict_count), 32'd2);
    reset = 1'b1;
    stalls("t5rst", 1'b1, 1'b1, 1'b1);
    tick();
    reset = 1'b0;
    chk("t5_wvalid_rst", 32'(rob_wvalid), 32'd0);
    chk("t5_cnt_rst", 32'(conflict_count), 32'd0);
    stalls("t5post", 1'b0, 1'b1, 1'b1);
    tick();
    chk("t5_src_restart", 32'(rob_wsrc), 32'd0);
    chk("t5_wvalid_restart", 32'(rob_wvalid), 32'd1);
    v[0] = 1'b0; v[1] = 1'b0; v[2] = 1'b0;

    // Saturation: 65541 contended cycles
    do_reset();
    v[0] = 1'b1; v[2] = 1'b1;
    for (int k = 0; k < 65541; k++) tick();
    chk("t6_cnt_sat", 32'(conflict_count), 32'h0000FFFF);
    tick();
    chk("t6_cnt_hold", 32'(conflict_count), 32'h0000FFFF);
    v[0] = 1'b0; v[2] = 1'b0;
    tick();
    chk("t6_cnt_idle", 32'(conflict_count), 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
